// File: rtl/profibus_rx.sv
// PROFIBUS UART character receiver: start, 8 data bits LSB first, even parity, stop.
// Each bit is sampled mid-cell, timed from the upstream falling-edge pulse.
module profibus_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       rx,
  input  logic       rx_falling,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bit;

  // cnt counts down to the next sample point; zero means "sample rx this cycle".
  // Loading HALF-1 on the falling edge puts the start sample HALF cycles later.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= 4'd0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (rx_falling) begin
          state <= S_START;
          cnt   <= HALF_LOAD;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= BIT_LOAD;
        case (state)
          S_START: begin
            if (rx) begin
              // Line already back high: treat as a glitch, leave outputs alone.
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              state   <= S_DATA;
              bit_idx <= 4'd0;
            end
          end
          S_DATA: begin
            shift   <= {rx, shift[7:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= rx;
            state   <= S_STOP;
          end
          S_STOP: begin
            state      <= S_IDLE;
            cnt        <= '0;
            data_valid <= 1'b1;
            data       <= shift;
            parity_err <= (^shift) ^ par_bit;
            frame_err  <= ~rx;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_profibus_rx.sv
// Directed bench for profibus_rx at CLKS_PER_BIT=8: good frames, parity and framing
// errors, start glitch, mid-character reset and back-to-back characters.
module tb_profibus_rx;

  logic       clk = 1'b0;
  logic       nreset;
  logic       rx;
  logic       rx_falling;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // cyc = index of the most recent rising edge. A register updated at edge e is
  // observed in cycle e+1, so monitor timestamps are cyc+1.
  int cyc = 0;
  int t0;
  int dv_cnt      = 0;
  int last_dv_cyc = -1;
  int prev_dv_cyc = -1;
  int busy_rise   = -1;
  int busy_fall   = -1;
  logic busy_q    = 1'b0;

  profibus_rx #(.CLKS_PER_BIT(8)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .rx         (rx),
    .rx_falling (rx_falling),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc + 1;
    end
    if (busy === 1'b1 && busy_q == 1'b0) busy_rise = cyc + 1;
    if (busy === 1'b0 && busy_q == 1'b1) busy_fall = cyc + 1;
    busy_q = (busy === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic idle(input int n);
    rx = 1'b1;
    rx_falling = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 11-bit character, 8 cycles per bit, generating rx_falling the way the
  // upstream edge detector would. abort_at >= 0 pulses nreset at edge t0+abort_at.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int abort_at);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (k == 0 && j == 0) t0 = cyc + 1;
        if (abort_at >= 0 && cyc + 1 == t0 + abort_at) begin
          nreset = 1'b0;
          @(negedge clk);
          nreset = 1'b1;
          rx = 1'b1;
          rx_falling = 1'b0;
          return;
        end
        rx_falling = (j == 0) && rx && !bits[k];
        rx = bits[k];
        @(negedge clk);
      end
    end
    rx_falling = 1'b0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    rx = 1'b1;
    rx_falling = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (data !== 8'h00) $display("FAIL reset_data got %h exp 00", data); else pass_cnt++;
    total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_dv got %b exp 0", data_valid); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_pe got %b exp 0", parity_err); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe got %b exp 0", frame_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL reset_state got %0d exp 0", state_dbg); else pass_cnt++;
    nreset = 1'b1;
    idle(3);
  endtask

  task automatic test_basic;
    int n0;
    n0 = dv_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(4);
    total_cnt++; if (dv_cnt !== n0 + 1) $display("FAIL basic_dv_count got %0d exp %0d", dv_cnt, n0 + 1); else pass_cnt++;
    total_cnt++; if (last_dv_cyc !== t0 + 85) $display("FAIL basic_dv_cycle got %0d exp %0d", last_dv_cyc, t0 + 85); else pass_cnt++;
    total_cnt++; if (busy_fall !== t0 + 85) $display("FAIL basic_busy_fall got %0d exp %0d", busy_fall, t0 + 85); else pass_cnt++;
    total_cnt++; if (busy_rise !== t0 + 1) $display("FAIL basic_busy_rise got %0d exp %0d", busy_rise, t0 + 1); else pass_cnt++;
    total_cnt++; if (data !== 8'hA5) $display("FAIL basic_data got %h exp a5", data); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL basic_pe got %b exp 0", parity_err); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL basic_fe got %b exp 0", frame_err); else pass_cnt++;
    total_cnt++; if (data_valid !== 1'b0) $display("FAIL basic_dv_low got %b exp 0", data_valid); else pass_cnt++;
  endtask

  task automatic test_parity_err;
    int n0;
    n0 = dv_cnt;
    send_frame(8'h01, 1'b0, 1'b1, -1);
    idle(4);
    total_cnt++; if (dv_cnt !== n0 + 1) $display("FAIL par_dv_count got %0d exp %0d", dv_cnt, n0 + 1); else pass_cnt++;
    total_cnt++; if (data !== 8'h01) $display("FAIL par_data got %h exp 01", data); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b1) $display("FAIL par_pe got %b exp 1", parity_err); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL par_fe got %b exp 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int n0;
    n0 = dv_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(4);
    total_cnt++; if (dv_cnt !== n0 + 1) $display("FAIL frm_dv_count got %0d exp %0d", dv_cnt, n0 + 1); else pass_cnt++;
    total_cnt++; if (last_dv_cyc !== t0 + 85) $display("FAIL frm_dv_cycle got %0d exp %0d", last_dv_cyc, t0 + 85); else pass_cnt++;
    total_cnt++; if (data !== 8'h3C) $display("FAIL frm_data got %h exp 3c", data); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL frm_fe got %b exp 1", frame_err); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL frm_pe got %b exp 0", parity_err); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int n0;
    n0 = dv_cnt;
    t0 = cyc + 1;
    rx_falling = 1'b1;
    rx = 1'b0;
    @(negedge clk);
    rx_falling = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(12);
    total_cnt++; if (busy_rise !== t0 + 1) $display("FAIL glitch_busy_rise got %0d exp %0d", busy_rise, t0 + 1); else pass_cnt++;
    total_cnt++; if (busy_fall !== t0 + 5) $display("FAIL glitch_busy_fall got %0d exp %0d", busy_fall, t0 + 5); else pass_cnt++;
    total_cnt++; if (dv_cnt !== n0) $display("FAIL glitch_dv_count got %0d exp %0d", dv_cnt, n0); else pass_cnt++;
    total_cnt++; if (state_dbg !== 3'd0) $display("FAIL glitch_state got %0d exp 0", state_dbg); else pass_cnt++;
    total_cnt++; if (data !== 8'h3C) $display("FAIL glitch_data_held got %h exp 3c", data); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL glitch_fe_held got %b exp 1", frame_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = dv_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 40);
    @(negedge clk);
    total_cnt++; if (data !== 8'h00) $display("FAIL rstmid_data got %h exp 00", data); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL rstmid_fe got %b exp 0", frame_err); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL rstmid_pe got %b exp 0", parity_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else pass_cnt++;
    idle(100);
    total_cnt++; if (dv_cnt !== n0) $display("FAIL rstmid_no_dv got %0d exp %0d", dv_cnt, n0); else pass_cnt++;
    send_frame(8'h55, 1'b0, 1'b1, -1);
    idle(4);
    total_cnt++; if (dv_cnt !== n0 + 1) $display("FAIL rstmid_next_dv got %0d exp %0d", dv_cnt, n0 + 1); else pass_cnt++;
    total_cnt++; if (data !== 8'h55) $display("FAIL rstmid_next_data got %h exp 55", data); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0 || frame_err !== 1'b0) $display("FAIL rstmid_next_err got pe=%b fe=%b exp 0 0", parity_err, frame_err); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n0;
    int ta;
    n0 = dv_cnt;
    send_frame(8'h12, 1'b0, 1'b1, -1);
    ta = t0;
    send_frame(8'hFE, 1'b1, 1'b1, -1);
    idle(4);
    total_cnt++; if (dv_cnt !== n0 + 2) $display("FAIL b2b_dv_count got %0d exp %0d", dv_cnt, n0 + 2); else pass_cnt++;
    total_cnt++; if (prev_dv_cyc !== ta + 85) $display("FAIL b2b_first_dv got %0d exp %0d", prev_dv_cyc, ta + 85); else pass_cnt++;
    total_cnt++; if (last_dv_cyc - prev_dv_cyc !== 88) $display("FAIL b2b_spacing got %0d exp 88", last_dv_cyc - prev_dv_cyc); else pass_cnt++;
    total_cnt++; if (data !== 8'hFE) $display("FAIL b2b_data got %h exp fe", data); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0 || frame_err !== 1'b0) $display("FAIL b2b_err got pe=%b fe=%b exp 0 0", parity_err, frame_err); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity_err;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
